// File: rtl/sr_flag_arbiter.sv
// sr_flag_arbiter: round-robin owner of a shared bank of set/reset flags.
// Requesters post "set/clear flag idx" commands. One command is granted at a
// time with a single-cycle GNT pulse. It is latched, then applied to FLAGS.
// Clear (CLR_ALL) dominates a coincident set, as in an SR flop with S=R=1.
//
// Handshake: a requester holds REQ/SET/IDX stable until it samples GNT high,
// and drops REQ no later than the following cycle. A REQ still high when the
// FSM is back in IDLE is a new command. GNT is a one-cycle pulse, never
// back-to-back, and exactly one bit is high while the FSM is in GRANT.
module sr_flag_arbiter #(
  parameter int NREQ  = 4,
  parameter int NFLAG = 8,
  parameter int IW    = 3
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic [NREQ-1:0]      REQ,
  input  logic [NREQ-1:0]      SET,
  input  logic [NREQ*IW-1:0]   IDX,
  input  logic                 CLR_ALL,
  output logic [NREQ-1:0]      GNT,
  output logic                 BUSY,
  output logic [2:0]           LAST_ID,
  output logic [NFLAG-1:0]     FLAGS,
  output logic [NFLAG-1:0]     FLAGS_BAR,
  output logic [1:0]           DBG_STATE,
  output logic [2:0]           DBG_PRI
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_GRANT = 2'd1;
  localparam logic [1:0] ST_APPLY = 2'd2;

  logic [1:0]       state;
  logic [2:0]       pri;
  logic             cmd_set;
  logic [IW-1:0]    cmd_idx;

  logic             arb_found;
  logic [2:0]       arb_win;
  logic             arb_set;
  logic [IW-1:0]    arb_idx;
  logic [3:0]       arb_c;
  logic [2:0]       pri_nxt;
  logic [NFLAG-1:0] flags_nxt;

  // Round-robin search starting at pri, wrapping modulo NREQ; first REQ wins.
  always_comb begin
    arb_found = 1'b0;
    arb_win   = '0;
    arb_set   = 1'b0;
    arb_idx   = '0;
    arb_c     = '0;
    for (int i = 0; i < NREQ; i++) begin
      arb_c = {1'b0, pri} + 4'(i);
      if (arb_c >= 4'(NREQ)) arb_c = arb_c - 4'(NREQ);
      for (int k = 0; k < NREQ; k++) begin
        if (!arb_found && (arb_c == 4'(k)) && REQ[k]) begin
          arb_found = 1'b1;
          arb_win   = 3'(k);
          arb_set   = SET[k];
          arb_idx   = IDX[k*IW +: IW];
        end
      end
    end
  end

  // Priority moves to the requester just after the winner.
  always_comb begin
    if (arb_win == 3'(NREQ - 1)) pri_nxt = 3'd0;
    else                         pri_nxt = arb_win + 3'd1;
  end

  // Sequencer: arbitrate in IDLE, pulse GNT in GRANT, write flags leaving APPLY.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state   <= ST_IDLE;
      pri     <= '0;
      cmd_set <= 1'b0;
      cmd_idx <= '0;
      GNT     <= '0;
      LAST_ID <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          GNT <= '0;
          if (arb_found) begin
            state   <= ST_GRANT;
            cmd_set <= arb_set;
            cmd_idx <= arb_idx;
            GNT     <= {{(NREQ-1){1'b0}}, 1'b1} << arb_win;
            LAST_ID <= arb_win;
            pri     <= pri_nxt;
          end
        end
        ST_GRANT: begin
          state <= ST_APPLY;
          GNT   <= '0;
        end
        ST_APPLY: begin
          state <= ST_IDLE;
          GNT   <= '0;
        end
        default: begin
          state <= ST_IDLE;
          GNT   <= '0;
        end
      endcase
    end
  end

  // Next flag value: clear-all dominates, else APPLY writes the latched bit.
  // An index at or above NFLAG matches no bit, so that write is dropped.
  always_comb begin
    flags_nxt = FLAGS;
    if (CLR_ALL) begin
      flags_nxt = '0;
    end else if (state == ST_APPLY) begin
      for (int f = 0; f < NFLAG; f++) begin
        if (cmd_idx == IW'(f)) flags_nxt[f] = cmd_set;
      end
    end
  end

  // Flag register.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) FLAGS <= '0;
    else     FLAGS <= flags_nxt;
  end

  assign FLAGS_BAR = ~FLAGS;
  assign BUSY      = (state != ST_IDLE);
  assign DBG_STATE = state;
  assign DBG_PRI   = pri;

endmodule

// File: tb/tb_sr_flag_arbiter.sv
// Directed bench for sr_flag_arbiter: an NFLAG=8 instance plus an NFLAG=6
// instance sharing the same stimulus for the out-of-range index case.
module tb_sr_flag_arbiter;

  logic        clk;
  logic        rst;
  logic [3:0]  req;
  logic [3:0]  set_op;
  logic [11:0] idx;
  logic        clr_all;

  logic [3:0]  gnt8, gnt6;
  logic        busy8, busy6;
  logic [2:0]  last8, last6;
  logic [7:0]  flags8, fbar8;
  logic [5:0]  flags6, fbar6;
  logic [1:0]  st8, st6;
  logic [2:0]  pri8, pri6;

  int n_pass;
  int n_checks;

  sr_flag_arbiter #(.NREQ(4), .NFLAG(8), .IW(3)) u_dut8 (
    .CLK(clk), .RST(rst), .REQ(req), .SET(set_op), .IDX(idx), .CLR_ALL(clr_all),
    .GNT(gnt8), .BUSY(busy8), .LAST_ID(last8), .FLAGS(flags8), .FLAGS_BAR(fbar8),
    .DBG_STATE(st8), .DBG_PRI(pri8)
  );

  sr_flag_arbiter #(.NREQ(4), .NFLAG(6), .IW(3)) u_dut6 (
    .CLK(clk), .RST(rst), .REQ(req), .SET(set_op), .IDX(idx), .CLR_ALL(clr_all),
    .GNT(gnt6), .BUSY(busy6), .LAST_ID(last6), .FLAGS(flags6), .FLAGS_BAR(fbar6),
    .DBG_STATE(st6), .DBG_PRI(pri6)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // Driver: one complete command from a single requester r.
  task automatic do_cmd(input int r, input logic s, input int fi);
    logic [3:0] exp_g;
    exp_g = 4'b0001 << r;
    req[r]          = 1'b1;
    set_op[r]       = s;
    idx[r*3 +: 3]   = 3'(fi);
    tick();
    chk("cmd_gnt8",  32'(gnt8),  32'(exp_g));
    chk("cmd_gnt6",  32'(gnt6),  32'(exp_g));
    chk("cmd_st_g",  32'(st8),   32'd1);
    chk("cmd_last",  32'(last8), 32'(r));
    req[r] = 1'b0;
    tick();
    chk("cmd_gnt_off", 32'(gnt8), 32'd0);
    chk("cmd_st_a",    32'(st8),  32'd2);
    tick();
    chk("cmd_st_i",    32'(st8),  32'd0);
    chk("cmd_busy",    32'(busy8), 32'd0);
  endtask

  task automatic pulse_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  initial begin
    n_pass   = 0;
    n_checks = 0;
    rst      = 1'b1;
    req      = '0;
    set_op   = '0;
    idx      = '0;
    clr_all  = 1'b0;
    tick();
    tick();

    // Reset state
    chk("rst_flags", 32'(flags8), 32'h00);
    chk("rst_fbar",  32'(fbar8),  32'hFF);
    chk("rst_gnt",   32'(gnt8),   32'h0);
    chk("rst_busy",  32'(busy8),  32'h0);
    chk("rst_last",  32'(last8),  32'h0);
    chk("rst_pri",   32'(pri8),   32'h0);
    rst = 1'b0;

    // Single command: requester 2 sets idx 5
    req[2] = 1'b1; set_op[2] = 1'b1; idx[8:6] = 3'd5;
    tick();
    chk("t1_gnt",  32'(gnt8),  32'b0100);
    chk("t1_busy", 32'(busy8), 32'd1);
    chk("t1_last", 32'(last8), 32'd2);
    req[2] = 1'b0;
    tick();
    chk("t2_gnt",   32'(gnt8),   32'd0);
    chk("t2_busy",  32'(busy8),  32'd1);
    chk("t2_flags", 32'(flags8), 32'h00);
    tick();
    chk("t3_flags", 32'(flags8), 32'h20);
    chk("t3_fbar",  32'(fbar8),  32'hDF);
    chk("t3_busy",  32'(busy8),  32'd0);
    chk("t3_pri",   32'(pri8),   32'd3);

    // Fairness: all requesters held high, each setting its own index
    pulse_reset();
    req = 4'hF; set_op = 4'hF; idx = {3'd3, 3'd2, 3'd1, 3'd0};
    for (int g = 0; g < 5; g++) begin
      tick();
      chk("fair_gnt",  32'(gnt8),  32'(4'b0001 << (g % 4)));
      chk("fair_last", 32'(last8), 32'(g % 4));
      chk("fair_pri",  32'(pri8),  32'((g % 4 + 1) % 4));
      if (g == 4) req = '0;
      tick();
      chk("fair_gap1", 32'(gnt8), 32'd0);
      tick();
      chk("fair_gap2", 32'(gnt8), 32'd0);
      if (g == 3) chk("fair_flags", 32'(flags8), 32'h0F);
    end
    chk("fair_flags_end", 32'(flags8), 32'h0F);

    // Clear conflict: fill to 0xFF, clear idx 3, then CLR_ALL against a set
    do_cmd(1, 1'b1, 4);
    do_cmd(2, 1'b1, 5);
    do_cmd(3, 1'b1, 6);
    do_cmd(0, 1'b1, 7);
    chk("fill_flags", 32'(flags8), 32'hFF);
    do_cmd(1, 1'b0, 3);
    chk("clr3_flags", 32'(flags8), 32'hF7);
    chk("clr3_fbar",  32'(fbar8),  32'h08);
    req[2] = 1'b1; set_op[2] = 1'b1; idx[8:6] = 3'd0;
    tick();
    chk("cf_gnt", 32'(gnt8), 32'b0100);
    req[2] = 1'b0;
    tick();
    chk("cf_st_apply", 32'(st8), 32'd2);
    clr_all = 1'b1;
    tick();
    clr_all = 1'b0;
    chk("cf_flags", 32'(flags8), 32'h00);
    chk("cf_fbar",  32'(fbar8),  32'hFF);
    chk("cf_state", 32'(st8),    32'd0);
    chk("cf_pri",   32'(pri8),   32'd3);

    // Mid-transaction reset: requester 3 sets idx 6, reset during GRANT
    req[3] = 1'b1; set_op[3] = 1'b1; idx[11:9] = 3'd6;
    tick();
    chk("mr_gnt", 32'(gnt8), 32'b1000);
    #2 rst = 1'b1;
    #1;
    chk("mr_async_state", 32'(st8),   32'd0);
    chk("mr_async_gnt",   32'(gnt8),  32'd0);
    chk("mr_async_busy",  32'(busy8), 32'd0);
    chk("mr_async_pri",   32'(pri8),  32'd0);
    #2 rst = 1'b0;
    req[3] = 1'b0;
    tick();
    tick();
    tick();
    chk("mr_flags", 32'(flags8), 32'h00);
    chk("mr_state", 32'(st8),    32'd0);
    do_cmd(3, 1'b1, 2);
    chk("mr_next_flags", 32'(flags8), 32'h04);
    chk("mr_next_pri",   32'(pri8),   32'd0);

    // Pointer wrap: after the grant to 3, requesters 0 and 1 both request
    req[0] = 1'b1; set_op[0] = 1'b1; idx[2:0] = 3'd0;
    req[1] = 1'b1; set_op[1] = 1'b1; idx[5:3] = 3'd1;
    tick();
    chk("wrap_gnt0", 32'(gnt8), 32'b0001);
    req[0] = 1'b0;
    tick();
    tick();
    tick();
    chk("wrap_gnt1", 32'(gnt8), 32'b0010);
    req[1] = 1'b0;
    tick();
    tick();
    chk("wrap_flags", 32'(flags8), 32'h07);

    // Out-of-range index on the NFLAG=6 instance
    pulse_reset();
    do_cmd(0, 1'b1, 2);
    chk("oor_pre6", 32'(flags6), 32'h04);
    do_cmd(1, 1'b1, 7);
    chk("oor_flags6", 32'(flags6), 32'h04);
    chk("oor_fbar6",  32'(fbar6),  32'h3B);
    chk("oor_last6",  32'(last6),  32'd1);
    chk("oor_flags8", 32'(flags8), 32'h84);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/sr_flag_arbiter.md
# sr_flag_arbiter

Round-robin controller that shares a bank of set/reset flag bits between several requesters. Each requester posts a set or clear command for one flag index. The block grants one requester at a time with a single-cycle `GNT` pulse, latches that command, and applies it to the flag register with reset-dominant SR semantics. It sits between the control agents and the status flags they share, and replaces per-agent SR flip-flops that would otherwise need ad-hoc priority logic.

## Interface
Parameters:
- `NREQ`, 4: number of requesters (2..8).
- `NFLAG`, 8: number of flag bits.
- `IW`, 3: flag index width; must satisfy 2^`IW` ≥ `NFLAG`.

Ports:
- `CLK`, in, 1: the single clock. All state updates on the rising edge.
- `RST`, in, 1: asynchronous, active-high reset.
- `REQ`, in, `NREQ`: per-requester command request. Level signal, held until granted.
- `SET`, in, `NREQ`: per-requester operation. 1 = set flag, 0 = clear flag.
- `IDX`, in, `NREQ*IW`: per-requester flag index. Requester k uses bits [k*IW +: IW].
- `CLR_ALL`, in, 1: synchronous clear of all flags.
- `GNT`, out, `NREQ`: one-hot grant pulse, one cycle wide.
- `BUSY`, out, 1: high whenever the FSM is not in IDLE.
- `LAST_ID`, out, 3: index of the most recently granted requester.
- `FLAGS`, out, `NFLAG`: flag register.
- `FLAGS_BAR`, out, `NFLAG`: bitwise complement of `FLAGS`.

## Operation
- FSM has three states: IDLE, GRANT, APPLY.
  - IDLE → GRANT when any `REQ` bit is high; otherwise stay in IDLE.
  - GRANT → APPLY unconditionally.
  - APPLY → IDLE unconditionally.
- Arbitration happens in IDLE:
  - Round-robin pointer `PRI` (0..NREQ-1) marks the highest-priority requester.
  - Search order is `PRI`, `PRI`+1, … with wrap modulo `NREQ`. The first requester with `REQ` high wins.
- On the edge entering GRANT:
  - Winner's `SET` and `IDX` are latched into the command register.
  - `GNT[winner]` is set and `LAST_ID` is updated to the winner.
  - `PRI` becomes (winner+1) mod `NREQ`.
- Requester protocol:
  - Hold `REQ`, `SET` and `IDX` stable until `GNT` is sampled high.
  - Deassert `REQ` on the following cycle at the latest.
  - A `REQ` still high in IDLE is treated as a new command.
- In APPLY, on the edge leaving APPLY:
  - `FLAGS[idx]` ← `SET`, i.e. set or clear the indexed bit.
  - If idx ≥ `NFLAG`, the write is dropped. The grant is still issued.
- `CLR_ALL` is sampled every cycle in every state:
  - When high, all `FLAGS` bits become 0 on the next edge.
  - If it coincides with an APPLY set, clear wins and the flag ends at 0 (reset-dominant, as in an SR flop with S=R=1).
  - `CLR_ALL` does not disturb FSM, `PRI` or `GNT`.
- `FLAGS_BAR` is combinational `~FLAGS` and is never X.

## Timing
- Reset values:
  - state IDLE, `PRI` 0, command register 0.
  - `GNT` 0, `BUSY` 0, `LAST_ID` 0.
  - `FLAGS` all 0, `FLAGS_BAR` all 1.
- `RST` asserted mid-transaction (GRANT or APPLY) aborts it immediately and asynchronously. The latched command is never applied.
- Latency, for `REQ` high in cycle t with the FSM in IDLE:
  - `GNT` high during t+1.
  - `FLAGS` updated and visible in t+2's successor cycle (edge ending APPLY).
  - `BUSY` high in t+1 and t+2.
- Throughput: one command per 3 cycles. With continuous requests from all agents, each requester is granted once every 3·`NREQ` cycles.
- `GNT` is never high for two consecutive cycles. Exactly one bit is high while in GRANT.
- Requests arriving while `BUSY` is high wait. They are arbitrated when the FSM returns to IDLE.

## Test plan
- Reset check: assert `RST` → `FLAGS`=0x00, `FLAGS_BAR`=0xFF, `GNT`=0, `BUSY`=0. Then `REQ[2]`=1, `SET[2]`=1, `IDX[2]`=5 → `GNT`=4'b0100 one cycle later, `FLAGS`=0x20 two edges after that, `LAST_ID`=2.
- Fairness: all four `REQ` held high, each setting its own index k → grant order 0,1,2,3,0, spaced 3 cycles apart; `FLAGS`=0x0F after the fourth APPLY.
- Clear conflict: `FLAGS`=0xFF, requester 1 clears idx 3 → `FLAGS`=0xF7. Then `CLR_ALL` in the same cycle as an APPLY setting idx 0 → `FLAGS`=0x00.
- Mid-transaction reset: `RST` pulsed during GRANT of a set to idx 6 → `FLAGS` stays 0x00, state IDLE, `PRI`=0. The next `REQ[3]` is granted normally.
- Out-of-range index: `NFLAG`=6, `IW`=3, set idx 7 → `GNT` still pulses and `FLAGS` is unchanged.
- Pointer wrap: sequential grants to 3 then 0 with `REQ[0]` and `REQ[1]` both high after the grant to 3 → requester 0 is granted before requester 1.
